ddr3_wr_oe_sched: RTL and testbench
===================================

# ddr3_wr_oe_sched

Write output-enable scheduler for the DDR3 PHY write path. Accepts write commands in the SCLK domain and generates per-SCLK tristate controls T0/T1 for the DQ and DQS tristate gearboxes (X2, active-low drive). It also generates the data-fetch requests that line up with each burst. It sits between the command sequencer and the DQ/DQS output gearing, with preamble, postamble and back-to-back burst merging handled here.

## Interface
- CWL_SCLK, 3: write latency from command accept to first DQ beat, in SCLK cycles; legal range 2..15.
- DATA_LEAD, 1: cycles by which wr_data_req leads the DQ window; legal range 0..CWL_SCLK-1.
- sclk  in  1  system clock (ECLK/2); all logic on rising edge.
- RSTB  in  1  reset, synchronous, active-high.
- wr_valid  in  1  write command request.
- wr_ready  out  1  command accepted when wr_valid & wr_ready at an sclk edge.
- dq_t0, dq_t1  out  1 each  DQ tristate, first/second ECLK half of SCLK; 0 = drive.
- dqs_t0, dqs_t1  out  1 each  DQS tristate, same encoding.
- wr_data_req  out  1  fetch one SCLK word of write data.
- wr_data_beat  out  1  0 = first word of burst, 1 = second.
- busy  out  1  any burst pending or in flight.

## Operation
- BL8 is 2 SCLK cycles per burst. Minimum command spacing is 2 SCLK (tCCD = 4 nCK).
- Command FSM has two states, ACCEPT and HOLD.
  - ACCEPT: wr_ready = 1. An accept moves the FSM to HOLD.
  - HOLD: wr_ready = 0 for exactly one cycle, then returns to ACCEPT.
- A pending-command delay line of CWL_SCLK+3 bits shifts every cycle. Bit 0 is set on accept.
- For a command accepted in cycle n, the registered outputs are:
  - DQ window, cycles n+CWL_SCLK and n+CWL_SCLK+1: dq_t0 = dq_t1 = 0.
  - DQS preamble, cycle n+CWL_SCLK-1: dqs_t0 = 1, dqs_t1 = 0.
  - DQS window: same two cycles as DQ, both 0.
  - DQS postamble, cycle n+CWL_SCLK+2: dqs_t0 = 0, dqs_t1 = 1.
  - Data fetch, cycles n+CWL_SCLK-DATA_LEAD and the following cycle: wr_data_req = 1, with wr_data_beat = 0 then 1.
- Merging: outputs are the AND (drive wins) of the contributions of every pending command. With spacing exactly 2, the postamble of burst A overlaps the preamble of burst B, so DQS stays 0/0 across the seam. DQ is continuously 0 for 4 cycles.
- Spacing 3: there is a one-cycle DQS gap, which shows postamble then preamble in the same cycle (dqs_t0 = 0, dqs_t1 = 0).
- busy = any delay-line bit set, or any output currently driving.

## Timing
- Reset values, asserted in the cycle after any edge with RSTB = 1:
  - dq_t0 = dq_t1 = dqs_t0 = dqs_t1 = 1.
  - wr_data_req = 0, wr_data_beat = 0, busy = 0.
  - wr_ready = 0; the FSM is forced to HOLD.
  - wr_ready = 1 in the first cycle after RSTB deasserts.
- Reset mid-burst: the delay line clears. All tristates return to 1 and wr_data_req returns to 0 in the next cycle, with no postamble. Bursts are not resumed.
- wr_valid while wr_ready = 0 is ignored and not queued; the requester holds wr_valid.
- Latency, accept to first DQ drive: exactly CWL_SCLK cycles, with no combinational path from inputs to outputs.
- The delay line has no overflow: spacing ≥ 2 bounds occupancy to ceil((CWL_SCLK+3)/2) commands.

## Configuration
- DDR3_WRLVL_EN: adds input wrlvl_en (1 bit).
- With the macro defined, while wrlvl_en = 1:
  - dqs_t0 = dqs_t1 = 0 and dq_t0 = dq_t1 = 1.
  - wr_ready = 0; pending commands keep draining, but their DQS contributions are overridden.
- Leaving wrlvl_en restores normal behaviour on the next cycle.
- Without the macro: no port, no logic; behaviour as above.

## Structure
- Shared package ddr3_phy_pkg holds:
  - the FSM enum (ACCEPT, HOLD);
  - constant BURST_SCLK = 2;
  - constant PRE_SCLK = 1;
  - tristate encoding constants T_DRIVE = 0 and T_HIZ = 1.
- One sub-module, ddr3_oe_window: a parameterised delay line plus window decode producing raw drive/fetch strobes. The top level owns the FSM, the merge logic and the output registers.

## Test plan
- Reset with CWL_SCLK = 3, DATA_LEAD = 1:
  - all tristates 1 and wr_ready = 0 during reset;
  - wr_ready = 1 in the first cycle after RSTB deasserts.
- Single accept at cycle 10:
  - dqs_t = 1/0 at 12;
  - dq and dqs 0/0 at 13–14;
  - dqs 0/1 at 15;
  - wr_data_req at 12–13 with beat 0, 1;
  - all outputs idle at 16.
- Accepts at 10 and 12 (wr_valid held high):
  - wr_ready pattern 1,0,1,0;
  - DQ driven continuously 13–16;
  - DQS preamble at 12, driven 0/0 through 16, postamble at 17.
- Accepts at 10 and 13: the seam cycle 15 shows dqs_t0 = 0, dqs_t1 = 0, and dq_t = 1/1.
- RSTB asserted at cycle 13 of a burst accepted at 10: all tristates 1 from 14, no postamble, busy = 0.
- With DDR3_WRLVL_EN and wrlvl_en = 1 for cycles 20–30:
  - dqs_t = 0/0, dq_t = 1/1, wr_ready = 0 throughout;
  - normal accept possible at 31.

Source files
------------

// File: rtl/ddr3_phy_pkg.sv
// Shared DDR3 PHY write-path types and constants.
// Optional write-levelling support elsewhere is controlled by macro DDR3_WRLVL_EN.
package ddr3_phy_pkg;

    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        HOLD   = 1'b1
    } cmd_state_e;

    localparam int   BURST_SCLK = 2;
    localparam int   PRE_SCLK   = 1;
    localparam logic T_DRIVE    = 1'b0;
    localparam logic T_HIZ      = 1'b1;

    function automatic logic tri_enc(input logic drive);
        return drive ? T_DRIVE : T_HIZ;
    endfunction

endpackage

// File: rtl/ddr3_wr_oe_sched_if.sv
// Command / tristate / fetch bundle of the write OE scheduler.
// The wrlvl_en member exists only when DDR3_WRLVL_EN is defined.
interface ddr3_wr_oe_sched_if;
    logic wr_valid;
    logic wr_ready;
    logic dq_t0;
    logic dq_t1;
    logic dqs_t0;
    logic dqs_t1;
    logic wr_data_req;
    logic wr_data_beat;
    logic busy;
`ifdef DDR3_WRLVL_EN
    logic wrlvl_en;
`endif

    modport master (
`ifdef DDR3_WRLVL_EN
        output wrlvl_en,
`endif
        output wr_valid,
        input  wr_ready,
        input  dq_t0,
        input  dq_t1,
        input  dqs_t0,
        input  dqs_t1,
        input  wr_data_req,
        input  wr_data_beat,
        input  busy
    );

    modport slave (
`ifdef DDR3_WRLVL_EN
        input  wrlvl_en,
`endif
        input  wr_valid,
        output wr_ready,
        output dq_t0,
        output dq_t1,
        output dqs_t0,
        output dqs_t1,
        output wr_data_req,
        output wr_data_beat,
        output busy
    );
endinterface

// File: rtl/ddr3_oe_window.sv
// Pending-command delay line and window decode; strobes are raw (pre-register)
// and refer to the cycle after the current one.
module ddr3_oe_window
    import ddr3_phy_pkg::*;
#(
    parameter int CWL_SCLK  = 3,
    parameter int DATA_LEAD = 1,
    parameter int LINE_W    = CWL_SCLK + 3
) (
    input  logic sclk,
    input  logic RSTB,
    input  logic i_accept,
    output logic o_dq_drv,
    output logic o_dqs0_drv,
    output logic o_dqs1_drv,
    output logic o_req,
    output logic o_beat,
    output logic o_pending
);
    // Tap k holds a command accepted k cycles ago; tap 0 is this cycle's accept.
    localparam int DQ_LO   = CWL_SCLK - 1;
    localparam int DQ_HI   = DQ_LO + BURST_SCLK - 1;
    localparam int PRE_IX  = DQ_LO - PRE_SCLK;
    localparam int POST_IX = DQ_HI + 1;
    localparam int REQ_LO  = CWL_SCLK - DATA_LEAD - 1;
    localparam int REQ_HI  = REQ_LO + BURST_SCLK - 1;

    logic [LINE_W-1:0]  r_line;
    logic [POST_IX:0]   w_tap;
    logic               w_dq;
    logic               w_req;

    always_ff @(posedge sclk) begin
        if (RSTB) begin
            r_line <= '0;
        end else begin
            r_line <= {r_line[LINE_W-2:0], i_accept};
        end
    end

    assign w_tap = {r_line[POST_IX-1:0], i_accept};

    always_comb begin
        w_dq  = 1'b0;
        w_req = 1'b0;
        for (int i = DQ_LO; i <= DQ_HI; i++) begin
            w_dq = w_dq | w_tap[i];
        end
        for (int i = REQ_LO; i <= REQ_HI; i++) begin
            w_req = w_req | w_tap[i];
        end
    end

    // Preamble drives only the second half, postamble only the first half.
    assign o_dq_drv   = w_dq;
    assign o_dqs0_drv = w_dq | w_tap[POST_IX];
    assign o_dqs1_drv = w_dq | w_tap[PRE_IX];
    assign o_req      = w_req;
    assign o_beat     = w_tap[REQ_HI];
    assign o_pending  = |r_line;

endmodule

// File: rtl/ddr3_wr_oe_sched.sv
// DDR3 write output-enable scheduler: command FSM, burst merge, registered T0/T1.
// Define DDR3_WRLVL_EN to add the wrlvl_en write-levelling override.
module ddr3_wr_oe_sched
    import ddr3_phy_pkg::*;
#(
    parameter int CWL_SCLK  = 3,
    parameter int DATA_LEAD = 1
) (
    input  logic              sclk,
    input  logic              RSTB,
    ddr3_wr_oe_sched_if.slave bus
);
    localparam logic [0:0] ST_ACCEPT = ACCEPT;
    localparam logic [0:0] ST_HOLD   = HOLD;

    logic [0:0] r_state;
    logic       r_dq_t;
    logic       r_dqs_t0;
    logic       r_dqs_t1;
    logic       r_req;
    logic       r_beat;

    logic w_accept;
    logic w_lvl_now;
    logic w_lvl_q;
    logic w_dq_drv;
    logic w_dqs0_drv;
    logic w_dqs1_drv;
    logic w_req;
    logic w_beat;
    logic w_pending;

`ifdef DDR3_WRLVL_EN
    logic r_lvl;

    always_ff @(posedge sclk) begin
        if (RSTB) begin
            r_lvl <= 1'b0;
        end else begin
            r_lvl <= bus.wrlvl_en;
        end
    end

    assign w_lvl_now = bus.wrlvl_en;
    assign w_lvl_q   = r_lvl;
`else
    assign w_lvl_now = 1'b0;
    assign w_lvl_q   = 1'b0;
`endif

    assign bus.wr_ready = (r_state == ST_ACCEPT) & ~w_lvl_q;
    assign w_accept     = bus.wr_valid & bus.wr_ready;

    ddr3_oe_window #(
        .CWL_SCLK  (CWL_SCLK),
        .DATA_LEAD (DATA_LEAD)
    ) u_window (
        .sclk       (sclk),
        .RSTB       (RSTB),
        .i_accept   (w_accept),
        .o_dq_drv   (w_dq_drv),
        .o_dqs0_drv (w_dqs0_drv),
        .o_dqs1_drv (w_dqs1_drv),
        .o_req      (w_req),
        .o_beat     (w_beat),
        .o_pending  (w_pending)
    );

    // Write levelling parks DQ and forces DQS low; fetches keep draining.
    always_ff @(posedge sclk) begin
        if (RSTB) begin
            r_state  <= ST_HOLD;
            r_dq_t   <= T_HIZ;
            r_dqs_t0 <= T_HIZ;
            r_dqs_t1 <= T_HIZ;
            r_req    <= 1'b0;
            r_beat   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCEPT: if (w_accept) r_state <= ST_HOLD;
                default:   r_state <= ST_ACCEPT;
            endcase
            r_dq_t   <= tri_enc(w_dq_drv & ~w_lvl_now);
            r_dqs_t0 <= tri_enc(w_dqs0_drv | w_lvl_now);
            r_dqs_t1 <= tri_enc(w_dqs1_drv | w_lvl_now);
            r_req    <= w_req;
            r_beat   <= w_beat;
        end
    end

    assign bus.dq_t0        = r_dq_t;
    assign bus.dq_t1        = r_dq_t;
    assign bus.dqs_t0       = r_dqs_t0;
    assign bus.dqs_t1       = r_dqs_t1;
    assign bus.wr_data_req  = r_req;
    assign bus.wr_data_beat = r_beat;
    assign bus.busy         = w_pending | (r_dq_t == T_DRIVE) |
                              (r_dqs_t0 == T_DRIVE) | (r_dqs_t1 == T_DRIVE);

endmodule

// File: tb/tb_ddr3_wr_oe_sched.sv
// Self-checking bench for ddr3_wr_oe_sched against a cycle-list reference model.
// Write-levelling scenario is built only when DDR3_WRLVL_EN is defined.
module tb_ddr3_wr_oe_sched;
    localparam int C = 3;
    localparam int L = 1;

    logic sclk;
    logic RSTB;

    ddr3_wr_oe_sched_if u_if ();

    ddr3_wr_oe_sched #(
        .CWL_SCLK  (C),
        .DATA_LEAD (L)
    ) u_dut (
        .sclk (sclk),
        .RSTB (RSTB),
        .bus  (u_if)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_q[$];
    bit prev_rst    = 1'b1;
    bit prev_acc    = 1'b0;
    bit prev_wrlvl  = 1'b0;
    bit exp_ready;
    logic [7:0] exp_v;
    logic [7:0] obs;

    assign obs = {u_if.wr_ready, u_if.dq_t0, u_if.dq_t1, u_if.dqs_t0, u_if.dqs_t1,
                  u_if.wr_data_req, u_if.wr_data_beat, u_if.busy};

    // Advance one cycle: predict this cycle's outputs from the accept history,
    // then apply this cycle's inputs and record whether they cause an accept.
    task automatic tick(input bit v, input bit r, input bit w);
        bit dq, d0, d1, rq, bt, pd;
        int d;
        @(posedge sclk);
        #1;
        cyc++;
        while (acc_q.size() > 0 && acc_q[0] + C + 4 < cyc) void'(acc_q.pop_front());
        dq = 0; d0 = 0; d1 = 0; rq = 0; bt = 0; pd = 0;
        foreach (acc_q[i]) begin
            d = cyc - acc_q[i];
            if (d >= C && d <= C + 1)         dq = 1;
            if (d >= C && d <= C + 2)         d0 = 1;
            if (d >= C - 1 && d <= C + 1)     d1 = 1;
            if (d >= C - L && d <= C - L + 1) rq = 1;
            if (d == C - L + 1)               bt = 1;
            if (d >= 1 && d <= C + 3)         pd = 1;
        end
        if (prev_wrlvl && !prev_rst) begin
            dq = 0; d0 = 1; d1 = 1;
        end
        exp_ready = !prev_rst && !prev_acc && !prev_wrlvl;
        exp_v = {exp_ready, ~dq, ~dq, ~d0, ~d1, rq, bt, pd | dq | d0 | d1};
        u_if.wr_valid = v;
        RSTB = r;
`ifdef DDR3_WRLVL_EN
        u_if.wrlvl_en = w;
`endif
        prev_acc = v && exp_ready && !r;
        if (prev_acc) acc_q.push_back(cyc);
        if (r) acc_q.delete();
        prev_rst   = r;
        prev_wrlvl = w;
    endtask

    task automatic test_reset();
        for (int t = 0; t < 6; t++) begin
            tick(1'b0, t < 4, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t < 4) begin
                n_checks++;
                if ({u_if.wr_ready, u_if.dq_t0, u_if.dq_t1, u_if.dqs_t0, u_if.dqs_t1} !== 5'b01111) begin
                    n_fail++;
                    $display("FAIL reset_idle t=%0d got=%b want=01111", t, obs);
                end
            end
        end
        n_checks++;
        if (u_if.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got=%b want=1", u_if.wr_ready);
        end
    endtask

    task automatic test_single();
        for (int t = 0; t <= 20; t++) begin
            tick(t == 10, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t == 12 || t == 15) begin
                n_checks++;
                if ({u_if.dqs_t0, u_if.dqs_t1} !== ((t == 12) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL single_dqs_edge t=%0d got=%b%b", t, u_if.dqs_t0, u_if.dqs_t1);
                end
            end
            if (t == 13) begin
                n_checks++;
                if ({u_if.dq_t0, u_if.dqs_t1, u_if.wr_data_req, u_if.wr_data_beat} !== 4'b0011) begin
                    n_fail++;
                    $display("FAIL single_first_beat got=%b want=0011", obs);
                end
            end
            if (t == 16) begin
                n_checks++;
                if ({u_if.dq_t0, u_if.dq_t1, u_if.dqs_t0, u_if.dqs_t1, u_if.wr_data_req} !== 5'b11110) begin
                    n_fail++;
                    $display("FAIL single_idle got=%b want=11110", obs);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_dq = 0;
        logic [3:0] rdy = '0;
        for (int t = 0; t <= 22; t++) begin
            tick(t >= 10 && t <= 12, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL b2b t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t >= 10 && t <= 13) rdy = {rdy[2:0], u_if.wr_ready};
            if (u_if.dq_t0 === 1'b0) n_dq++;
            if (t >= 13 && t <= 16) begin
                n_checks++;
                if ({u_if.dq_t0, u_if.dqs_t0, u_if.dqs_t1} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL b2b_seam t=%0d got=%b want=000", t, obs);
                end
            end
        end
        n_checks++;
        if (rdy !== 4'b1010) begin
            n_fail++;
            $display("FAIL b2b_ready got=%b want=1010", rdy);
        end
        n_checks++;
        if (n_dq !== 4) begin
            n_fail++;
            $display("FAIL b2b_dq_len got=%0d want=4", n_dq);
        end
    endtask

    task automatic test_gap3();
        for (int t = 0; t <= 22; t++) begin
            tick(t == 10 || t == 13, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL gap3 t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t == 15) begin
                n_checks++;
                if ({u_if.dq_t0, u_if.dq_t1, u_if.dqs_t0, u_if.dqs_t1} !== 4'b1100) begin
                    n_fail++;
                    $display("FAIL gap3_seam got=%b want=1100", obs);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t <= 20; t++) begin
            tick(t == 10, t == 13, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t >= 14 && t <= 16) begin
                n_checks++;
                if ({u_if.dq_t0, u_if.dq_t1, u_if.dqs_t0, u_if.dqs_t1, u_if.wr_data_req, u_if.busy} !== 6'b111100) begin
                    n_fail++;
                    $display("FAIL reset_mid_quiet t=%0d got=%b want=111100", t, obs);
                end
            end
        end
    endtask

`ifdef DDR3_WRLVL_EN
    task automatic test_wrlvl();
        for (int t = 0; t <= 42; t++) begin
            tick(t == 17 || (t >= 22 && t <= 31), 1'b0, t >= 19 && t <= 29);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wrlvl t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t >= 20 && t <= 30) begin
                n_checks++;
                if ({u_if.wr_ready, u_if.dq_t0, u_if.dq_t1, u_if.dqs_t0, u_if.dqs_t1} !== 5'b01100) begin
                    n_fail++;
                    $display("FAIL wrlvl_force t=%0d got=%b want=01100", t, obs);
                end
            end
            if (t == 31) begin
                n_checks++;
                if (u_if.wr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrlvl_exit_ready got=%b want=1", u_if.wr_ready);
                end
            end
            if (t == 34) begin
                n_checks++;
                if (u_if.dq_t0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrlvl_exit_burst got=%b want=0", u_if.dq_t0);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        bit lvl = 1'b0;
        for (int t = 0; t < 1500; t++) begin
`ifdef DDR3_WRLVL_EN
            if ($urandom_range(0, 31) == 0) lvl = ~lvl;
`endif
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0, lvl);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random t=%0d got=%b want=%b", t, obs, exp_v);
            end
        end
        for (int t = 0; t < 10; t++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RSTB = 1'b1;
        u_if.wr_valid = 1'b0;
`ifdef DDR3_WRLVL_EN
        u_if.wrlvl_en = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_gap3();
        test_reset_mid();
`ifdef DDR3_WRLVL_EN
        test_wrlvl();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
